// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the stream_mux block.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output stage occupancy; FULL is exactly out_valid=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between N producers, the mux and its single consumer.
interface stream_mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   grant;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, grant
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, grant
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority search: first requester after ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);
    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] w_idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (w_idx == SEL_W'(N - 1)) ? '0 : w_idx + SEL_W'(1);
            if (!gnt_any && req[w_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-way valid/ready stream multiplexer with a registered single-entry output stage,
// selecting by explicit index (mode 0) or round-robin among valid channels (mode 1).
module stream_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input logic         clk,
    input logic         rst_n,
    stream_mux_if.slave bus
);
    localparam int SEL_W = $clog2(N);
    localparam logic [SEL_W:0] LP_N = (SEL_W + 1)'(N);

    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_grant;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [SEL_W-1:0] w_chan;
    logic             w_chosen;
    logic             w_load_en;
    logic             w_xfer;
    logic [N-1:0]     w_ready;
    logic [WIDTH-1:0] w_data;

    rr_arbiter #(.N(N)) u_arb (
        .req     (bus.in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    always_comb begin
        w_load_en = (r_state == ST_EMPTY) || bus.out_ready;
        w_chan    = '0;
        w_chosen  = 1'b0;
        if (bus.mode == MODE_RR) begin
            w_chan   = w_arb_idx;
            w_chosen = w_arb_any;
        end else begin
            w_chan   = bus.sel;
            w_chosen = ({1'b0, bus.sel} < LP_N);
        end

        // Ready ignores in_valid of the chosen channel in fixed mode; rst_n masks it during reset.
        w_ready = '0;
        w_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_ready[i] = rst_n && w_load_en && w_chosen && (w_chan == SEL_W'(i));
            if (w_chan == SEL_W'(i)) begin
                w_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
        w_xfer = |(w_ready & bus.in_valid);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load_en) begin
            w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_grant <= '0;
            r_ptr   <= SEL_W'(N - 1);
        end else if (w_xfer) begin
            r_data  <= w_data;
            r_grant <= w_chan;
            if (bus.mode == MODE_RR) begin
                r_ptr <= w_chan;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_data;
    assign bus.grant     = r_grant;

endmodule

// File: tb/tb_stream_mux.sv
// Randomised and directed bench for stream_mux against a queue-free behavioural model.
module tb_stream_mux;
    import mux_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_mux_if #(.WIDTH(W), .N(N)) b4 ();
    stream_mux_if #(.WIDTH(W), .N(3)) b3 ();

    stream_mux #(.WIDTH(W), .N(N)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    stream_mux #(.WIDTH(W), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    int n_checks = 0;
    int n_errors = 0;

    int m_valid, m_data, m_grant, m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_grant = 0;
        m_ptr   = N - 1;
    endtask

    // Chosen channel from the rules: fixed index, or first valid after ptr going round mod N.
    task automatic pick(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        if (b4.mode == MODE_RR) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!ok && b4.in_valid[j]) begin
                    ok = 1'b1;
                    c  = j;
                end
            end
        end else begin
            c  = int'(b4.sel);
            ok = (c < N);
        end
    endtask

    task automatic tick();
        int c;
        bit ok, load, xfer, rr;
        logic [N-1:0] er;
        int nd;
        #1;
        pick(c, ok);
        load = (m_valid == 0) || b4.out_ready;
        er = '0;
        if (load && ok) er[c] = 1'b1;
        chk("in_ready", 32'(b4.in_ready), 32'(er));
        xfer = load && ok && b4.in_valid[c];
        nd   = ok ? int'(b4.in_data[c*W +: W]) : 0;
        rr   = (b4.mode == MODE_RR);
        @(posedge clk);
        #1;
        if (xfer) begin
            m_valid = 1;
            m_data  = nd;
            m_grant = c;
            if (rr) m_ptr = c;
        end else if (load) begin
            m_valid = 0;
        end
        chk("out_valid", 32'(b4.out_valid), 32'(m_valid));
        chk("out_data", 32'(b4.out_data), 32'(m_data));
        chk("grant", 32'(b4.grant), 32'(m_grant));
    endtask

    initial begin
        rst_n        = 1'b0;
        b4.in_data   = 32'h13121110;
        b4.in_valid  = '1;
        b4.mode      = MODE_RR;
        b4.sel       = '0;
        b4.out_ready = 1'b1;
        b3.in_data   = '0;
        b3.in_valid  = '1;
        b3.mode      = MODE_FIXED;
        b3.sel       = '0;
        b3.out_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_out_data", 32'(b4.out_data), 32'd0);
        chk("rst_grant", 32'(b4.grant), 32'd0);
        chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
        chk("rst3_in_ready", 32'(b3.in_ready), 32'd0);
        chk("rst3_out_valid", 32'(b3.out_valid), 32'd0);
        rst_n = 1'b1;

        // Round-robin with all channels valid: grants 0,1,2,3,0,...
        b3.in_valid = '0;
        repeat (8) tick();

        // Fixed select on ch2; N=3 instance then given an out-of-range select.
        b4.mode = MODE_FIXED;
        b4.sel = 2'd2;
        b4.in_valid = 4'b0100;
        b4.in_data = 32'h00A50000;
        b3.sel = 2'd2;
        b3.in_valid = 3'b100;
        b3.in_data = 24'h5A0000;
        tick();
        chk("n3_sel2_valid", 32'(b3.out_valid), 32'd1);
        chk("n3_sel2_data", 32'(b3.out_data), 32'h5A);
        chk("n3_sel2_grant", 32'(b3.grant), 32'd2);
        b3.sel = 2'd3;
        b3.in_valid = 3'b111;
        #1;
        chk("n3_sel3_ready", 32'(b3.in_ready), 32'd0);
        tick();
        chk("n3_sel3_valid", 32'(b3.out_valid), 32'd0);
        chk("n3_sel3_data", 32'(b3.out_data), 32'h5A);
        chk("n3_sel3_grant", 32'(b3.grant), 32'd2);

        // Back-pressure with a held 0x11, then drain and load ch3 together.
        b4.sel = 2'd1;
        b4.in_valid = 4'b0010;
        b4.in_data = 32'h33001100;
        tick();
        b4.out_ready = 1'b0;
        b4.in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            b4.sel = (k == 0) ? 2'd1 : 2'd3;
            tick();
        end
        chk("bp_held_data", 32'(b4.out_data), 32'h11);
        b4.out_ready = 1'b1;
        tick();
        chk("bp_reload_grant", 32'(b4.grant), 32'd3);

        // Sparse round-robin: park ptr on 0, then ch3/ch0 alternate.
        b4.mode = MODE_RR;
        b4.in_valid = 4'b0001;
        b4.in_data = 32'h40302010;
        tick();
        b4.in_valid = 4'b1001;
        repeat (4) tick();
        b4.in_valid = 4'b0000;
        repeat (2) tick();
        chk("sparse_drained", 32'(b4.out_valid), 32'd0);

        // Reset while FULL: word discarded without a clock edge.
        b4.in_valid = 4'b1111;
        b4.out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(b4.out_valid), 32'd0);
        chk("async_rst_data", 32'(b4.out_data), 32'd0);
        chk("async_rst_ready", 32'(b4.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b4.in_valid = 4'b0000;
        b4.out_ready = 1'b1;
        repeat (2) tick();

        for (int it = 0; it < 400; it++) begin
            if (it % 20 == 0) b4.mode = 1'($urandom_range(0, 1));
            b4.in_data   = $urandom;
            b4.in_valid  = 4'($urandom);
            b4.sel       = 2'($urandom_range(0, 3));
            b4.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
